// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
// It holds the op encodings, the sequencer state type and the data width.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  // The three opcodes above are legal; every other encoding is illegal.
  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op > ALU_XOR);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// The search starts at i_ptr, moves upward and wraps. o_grant is one-hot and
// o_found is set when any request bit is high.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic            o_found
);

  logic [PW:0] w_idx;

  // Walk NREQ positions from the pointer and grant the first requester found.
  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) w_idx = w_idx - (PW+1)'(NREQ);
      if (!o_found && i_req[w_idx[PW-1:0]]) begin
        o_grant[w_idx[PW-1:0]] = 1'b1;
        o_found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between NREQ
// requesters, with a valid/ready request side and a valid/ready response side.
// Optional feature macro: ALU_ARB_OPCHK_EN. When it is defined, illegal
// opcodes are answered with rsp_err and are never issued to the ALU.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. req_ready is one-hot and is only raised in IDLE.
// rsp_valid is one-hot to the owner, and the rsp_* outputs stay stable until
// rsp_ready of the owner is seen. rsp_ready bits of non-owners are ignored.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3*NREQ-1:0]      req_op,
  input  logic [32*NREQ-1:0]     req_a,
  input  logic [32*NREQ-1:0]     req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_zero,
  output logic                   rsp_overflow,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [2:0]             alu_ctrl,
  input  logic [DATA_W-1:0]      alu_r,
  input  logic                   alu_zero,
  input  logic                   alu_overflow,
  output logic [1:0]             dbg_state
);

  state_t              r_state;
  state_t              w_next;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_owner;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_zero;
  logic                r_rsp_ovf;

  logic [NREQ-1:0]     w_grant;
  logic                w_found;
  logic [PW-1:0]       w_idx;
  logic [2:0]          w_sel_op;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic                w_accept;
  logic                w_rsp_ack;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_found (w_found)
  );

  // Turn the one-hot grant into an index and mux out the winner's operation.
  always_comb begin
    w_idx    = '0;
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_idx    = PW'(i);
        w_sel_op = req_op[3*i +: 3];
        w_sel_a  = req_a[32*i +: 32];
        w_sel_b  = req_b[32*i +: 32];
      end
    end
  end

  assign w_accept  = (r_state == IDLE) && w_found;
  assign w_rsp_ack = (r_state == RESP) && rsp_ready[r_owner];

  // Next-state logic of the issue/capture/respond sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_found) begin
`ifdef ALU_ARB_OPCHK_EN
          w_next = op_is_illegal(w_sel_op) ? RESP : EXEC;
`else
          w_next = EXEC;
`endif
        end
      end
      EXEC:    w_next = CAPT;
      CAPT:    w_next = RESP;
      RESP:    if (w_rsp_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef ALU_ARB_OPCHK_EN
  logic r_rsp_err;
`endif

  // State, pointer, hold registers and captured response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_op       <= ALU_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_ovf  <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      r_rsp_err  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_idx;
        r_ptr   <= (w_idx == PW'(NREQ-1)) ? '0 : w_idx + PW'(1);
`ifdef ALU_ARB_OPCHK_EN
        if (op_is_illegal(w_sel_op)) begin
          // The ALU never sees this op; the hold regs keep the last issued one.
          r_rsp_data <= '0;
          r_rsp_zero <= 1'b1;
          r_rsp_ovf  <= 1'b0;
          r_rsp_err  <= 1'b1;
        end else begin
          r_op <= w_sel_op;
          r_a  <= w_sel_a;
          r_b  <= w_sel_b;
        end
`else
        r_op <= w_sel_op;
        r_a  <= w_sel_a;
        r_b  <= w_sel_b;
`endif
      end
      if (r_state == CAPT) begin
        r_rsp_data <= alu_r;
        r_rsp_zero <= alu_zero;
        r_rsp_ovf  <= alu_overflow;
`ifdef ALU_ARB_OPCHK_EN
        r_rsp_err  <= 1'b0;
`endif
      end
    end
  end

`ifdef ALU_ARB_OPCHK_EN
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready    = w_accept ? w_grant : '0;
  assign rsp_valid    = (r_state == RESP) ? (NREQ'(1) << r_owner) : '0;
  assign rsp_data     = r_rsp_data;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_overflow = r_rsp_ovf;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_ctrl     = r_op;
  assign dbg_state    = r_state;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single registered 32-bit ALU (ADD/SUB/XOR, one-cycle registered result) between NREQ requesters. Each requester hands over one operation with a valid/ready handshake. The arbiter drives the ALU operand and control inputs, waits out the ALU register stage, and captures result, zero and overflow. It then returns them to the owning requester with a valid/ready response handshake. It sits between the decode/issue logic and the ALU.

## Interface
- NREQ, 2: number of requesters, legal 2–4
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  one-hot accept; at most one bit high
- req_op  in  3*NREQ  per-requester ALU op, slice i = [3i+2:3i]: 000 ADD, 001 SUB, 010 XOR, others illegal
- req_a, req_b  in  32*NREQ  per-requester operands, slice i = [32i+31:32i]
- rsp_valid  out  NREQ  one-hot response valid to owner
- rsp_ready  in  NREQ  per-requester response accept
- rsp_data  out  32  result (shared bus)
- rsp_zero  out  1  result == 0
- rsp_overflow  out  1  ALU overflow/borrow bit (ADD/SUB), 0 for XOR
- rsp_err  out  1  illegal opcode flag (see Configuration)
- alu_a, alu_b  out  32  ALU operands
- alu_ctrl  out  3  ALU control
- alu_r  in  32  ALU registered result
- alu_zero  in  1  ALU zero flag
- alu_overflow  in  1  ALU overflow flag

## Operation
- The FSM has four states.
  - IDLE: if any req_valid is set, the round-robin pick chooses the winner w, searching from ptr upward and wrapping. req_ready[w]=1 combinationally in that same cycle. On that edge, latch op/a/b into hold regs, record owner=w, set ptr=(w+1) mod NREQ, and go to EXEC.
  - EXEC: the ALU samples the hold regs at the end of this cycle. Go to CAPT.
  - CAPT: alu_r, alu_zero and alu_overflow are valid. Capture them into rsp_data, rsp_zero and rsp_overflow. Go to RESP.
  - RESP: rsp_valid[owner]=1 and the rsp_* outputs are held stable. When rsp_ready[owner] is high, return to IDLE on that edge.
- alu_a, alu_b and alu_ctrl always equal the hold regs.
- req_ready is 0 outside IDLE. A requester must hold req_valid and its operands until it sees ready.
- rsp_ready bits of non-owners are ignored.
- A requester that deasserts valid before it is granted loses nothing; it is simply skipped.
- Arithmetic: results are modulo 2^32 with no sign extension. rsp_overflow is the ALU carry-out for ADD and the borrow for SUB, passed through unmodified.
- Reset:
  - Every output is 0: req_ready, rsp_valid, rsp_data, rsp_zero, rsp_overflow, rsp_err, alu_a, alu_b, alu_ctrl (ADD 0+0).
  - FSM goes to IDLE, ptr goes to 0, and any in-flight operation is dropped with no response.

## Timing
- Accept edge T leads to EXEC in cycle T+1, CAPT in T+2, and rsp_valid from T+3.
- Minimum occupancy is 4 cycles per operation when rsp_ready is tied high.
- With rsp_ready held low the arbiter stalls in RESP indefinitely. No new grant is issued while stalled.
- Reset asserted in any state takes effect at the next edge. The arbiter is in IDLE with ptr=0 in the first cycle after reset deasserts.
- When multiple requesters are valid simultaneously, exactly one is granted. With all NREQ valid continuously, grants rotate 0,1,…,NREQ-1,0.

## Configuration
- ALU_ARB_OPCHK_EN, defined: an illegal op (011–111) is accepted normally but never issued.
  - The hold regs keep the previous op and operands.
  - The FSM goes IDLE→RESP directly with rsp_err=1, rsp_data=0, rsp_zero=1 and rsp_overflow=0.
  - Latency from the accept edge to rsp_valid is 1 cycle.
- ALU_ARB_OPCHK_EN, not defined: illegal ops are forwarded to the ALU like any other op.
  - The ALU returns 0, so rsp_data=0 and rsp_zero=1.
  - rsp_err is tied 0.

## Structure
- Shared package alu_pkg holds:
  - the op encodings: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_XOR=3'b010;
  - the FSM state typedef (IDLE, EXEC, CAPT, RESP);
  - the data width constant 32.
- One sub-module: rr_pick, a combinational round-robin picker (inputs req vector and ptr; outputs a one-hot grant and a found flag), reused by any future shared-resource arbiter.
- The ALU is instantiated at the parent level, not inside alu_arbiter.

## Test plan
- Single ADD: requester 0, A=5, B=7, rsp_ready=1. req_ready[0] at T; rsp_valid[0] at T+3 with data 12, zero 0, overflow 0.
- SUB to zero and overflow:
  - Requester 1 SUB 9−9 → data 0, zero 1.
  - ADD 0xFFFFFFFF+1 → data 0, overflow 1, zero 1.
- Fairness: both requesters valid continuously with XOR ops for 6 grants. Grant order is 0,1,0,1,0,1; each rsp_data equals A^B for its owner.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles in RESP. rsp_valid[0] and rsp_data stay stable, no req_ready is issued, and completion follows the cycle after rsp_ready rises.
- Reset mid-operation: assert reset during EXEC. Next cycle all outputs are 0 and the FSM is in IDLE with no rsp_valid. The following grant with both requesters valid goes to requester 0.
- Illegal op 3'b101:
  - With ALU_ARB_OPCHK_EN defined: rsp_valid at T+1, rsp_err=1, data 0, and alu_ctrl unchanged.
  - Without the macro: rsp_valid at T+3, data 0, rsp_err=0.
